// File: rtl/sa_store_unit_pkg.sv
// Shared definitions for the store unit: store-size codes (the same encoding as
// the load trimmer's LW/LH/LB), beat FSM states and a buffered-store record.
package sa_store_unit_pkg;

  typedef enum logic [2:0] {
    ST_SW = 3'b000,
    ST_SH = 3'b001,
    ST_SB = 3'b010
  } st_ctl_e;

  localparam st_ctl_e LW = ST_SW;
  localparam st_ctl_e LH = ST_SH;
  localparam st_ctl_e LB = ST_SB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  ctl;
  } st_entry_t;

  function automatic logic ctl_legal(input logic [2:0] c);
    return (c == ST_SW) || (c == ST_SH) || (c == ST_SB);
  endfunction

  // Unshifted byte-enable pattern for a store size; zero for illegal codes.
  function automatic logic [3:0] base_be(input logic [2:0] c);
    logic [3:0] be;
    be = 4'b0000;
    case (c)
      ST_SW:   be = 4'b1111;
      ST_SH:   be = 4'b0011;
      ST_SB:   be = 4'b0001;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sa_store_unit_if.sv
// Store-unit bus: EX store request, MA load-conflict probe and the data-memory
// write port. slave = the store unit, master = its surroundings.
interface sa_store_unit_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_ctl;
  logic        st_err;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;

  modport slave (
    input  st_valid, st_addr, st_data, st_ctl, ld_addr, mem_ack,
    output st_ready, st_err, ld_conflict, mem_req, mem_addr, mem_wdata, mem_be, busy
  );

  modport master (
    output st_valid, st_addr, st_data, st_ctl, ld_addr, mem_ack,
    input  st_ready, st_err, ld_conflict, mem_req, mem_addr, mem_wdata, mem_be, busy
  );
endinterface

// File: rtl/sa_store_lane.sv
// Combinational lane former: places a right-justified store onto the byte lanes
// of the (up to) two words it touches.
module sa_store_lane
  import sa_store_unit_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  ctl_i,
  output logic [3:0]  be_lo_o,
  output logic [3:0]  be_hi_o,
  output logic [31:0] d_lo_o,
  output logic [31:0] d_hi_o,
  output logic        split_o,
  output logic        illegal_o
);

  logic [31:0] data_m;
  logic [7:0]  be8;
  logic [63:0] d64;

  always_comb begin
    data_m = 32'h0;
    case (ctl_i)
      ST_SW:   data_m = data_i;
      ST_SH:   data_m = {16'h0, data_i[15:0]};
      ST_SB:   data_m = {24'h0, data_i[7:0]};
      default: data_m = 32'h0;
    endcase
  end

  assign be8       = {4'b0000, base_be(ctl_i)} << off_i;
  assign d64       = {32'h0, data_m} << {off_i, 3'b000};
  assign be_lo_o   = be8[3:0];
  assign be_hi_o   = be8[7:4];
  assign d_lo_o    = d64[31:0];
  assign d_hi_o    = d64[63:32];
  assign split_o   = |be8[7:4];
  assign illegal_o = !ctl_legal(ctl_i);

endmodule

// File: rtl/sa_store_unit.sv
// Store buffer plus beat sequencer driving a word-aligned data-memory write port;
// misaligned stores go out as two beats, and MA loads are checked for conflicts.
//
//  state | meaning
//  IDLE  | buffer empty, no write request
//  BEAT0 | head entry's first (lower) word on the memory port
//  BEAT1 | head entry's second word (split stores only)
module sa_store_unit
  import sa_store_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sa_store_unit_if.slave bus_io
);

  localparam int AW = $clog2(DEPTH);

  st_entry_t       buf_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count, count_nxt;
  logic [AW-1:0]   rd_idx, wr_idx;
  state_e          state_q, state_d;
  logic            err_q;
  logic            full, accept, enq, pop;

  logic [3:0]      be_lo_a [DEPTH];
  logic [3:0]      be_hi_a [DEPTH];
  logic [31:0]     d_lo_a  [DEPTH];
  logic [31:0]     d_hi_a  [DEPTH];
  logic [DEPTH-1:0] split_a, hit_a, illegal_unused;
  logic [29:0]     ld_word, hd_word;
  logic            ld_off_unused;

  assign rd_idx = rd_ptr_q[AW-1:0];
  assign wr_idx = wr_ptr_q[AW-1:0];
  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

  // Readiness ignores a same-cycle pop so nothing bypasses a full buffer.
  assign accept = bus_io.st_valid && !full;
  assign enq    = accept && ctl_legal(bus_io.st_ctl);

  assign wr_ptr_d  = wr_ptr_q + (AW+1)'(enq);
  assign rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
  assign count_nxt = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      err_q    <= accept && !ctl_legal(bus_io.st_ctl);
      if (enq) buf_q[wr_idx] <= '{addr: bus_io.st_addr, data: bus_io.st_data, ctl: bus_io.st_ctl};
    end
  end

  assign ld_word       = bus_io.ld_addr[31:2];
  assign ld_off_unused = ^bus_io.ld_addr[1:0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [AW-1:0] rel;
    logic [29:0]   word;
    logic          live, lo_done;

    sa_store_lane u_lane (
      .off_i    (buf_q[g].addr[1:0]),
      .data_i   (buf_q[g].data),
      .ctl_i    (buf_q[g].ctl),
      .be_lo_o  (be_lo_a[g]),
      .be_hi_o  (be_hi_a[g]),
      .d_lo_o   (d_lo_a[g]),
      .d_hi_o   (d_hi_a[g]),
      .split_o  (split_a[g]),
      .illegal_o(illegal_unused[g])
    );

    assign rel     = AW'(g) - rd_idx;
    assign live    = {1'b0, rel} < count;
    assign word    = buf_q[g].addr[31:2];
    // The head's lower word no longer conflicts once its first beat was acked.
    assign lo_done = (AW'(g) == rd_idx) && (state_q == BEAT1);
    assign hit_a[g] = live && (((word == ld_word) && !lo_done) ||
                               (split_a[g] && ((word + 30'd1) == ld_word)));
  end

  assign hd_word = buf_q[rd_idx].addr[31:2];

  always_comb begin
    state_d          = state_q;
    pop              = 1'b0;
    bus_io.mem_req   = 1'b0;
    bus_io.mem_addr  = 32'h0;
    bus_io.mem_wdata = 32'h0;
    bus_io.mem_be    = 4'b0000;
    case (state_q)
      IDLE: begin
        if (enq || (count != '0)) state_d = BEAT0;
      end
      BEAT0: begin
        bus_io.mem_req   = 1'b1;
        bus_io.mem_addr  = {hd_word, 2'b00};
        bus_io.mem_wdata = d_lo_a[rd_idx];
        bus_io.mem_be    = be_lo_a[rd_idx];
        if (bus_io.mem_ack) begin
          if (split_a[rd_idx]) begin
            state_d = BEAT1;
          end else begin
            pop     = 1'b1;
            state_d = (count_nxt != '0) ? BEAT0 : IDLE;
          end
        end
      end
      BEAT1: begin
        bus_io.mem_req   = 1'b1;
        bus_io.mem_addr  = {hd_word + 30'd1, 2'b00};
        bus_io.mem_wdata = d_hi_a[rd_idx];
        bus_io.mem_be    = be_hi_a[rd_idx];
        if (bus_io.mem_ack) begin
          pop     = 1'b1;
          state_d = (count_nxt != '0) ? BEAT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.st_ready    = !full;
  assign bus_io.st_err      = err_q;
  assign bus_io.ld_conflict = |hit_a;
  assign bus_io.busy        = (count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_sa_store_unit.sv
// Bench for sa_store_unit: directed cases with literal expectations, then random
// traffic, all compared every cycle against a queue-of-beats reference model.
module tb_sa_store_unit;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sa_store_unit_if bus ();

  sa_store_unit #(.DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  beat_t beat_q[$];   // every write beat still owed to memory, in order
  int    ent_q[$];    // beats remaining per buffered store
  logic  err_exp = 1'b0;
  int    acc_cnt = 0;

  function automatic void push_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    int          sz, ln, bi, nb;
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic [31:0] w0;
    logic [1:0]  off;
    beat_t       b;
    sz  = (c == 3'd0) ? 4 : (c == 3'd1) ? 2 : 1;
    off = a[1:0];
    w0  = {a[31:2], 2'b00};
    wd[0] = 32'h0; wd[1] = 32'h0; be[0] = 4'h0; be[1] = 4'h0;
    for (int k = 0; k < sz; k++) begin
      ln = int'(off) + k;
      bi = ln / 4;
      wd[bi][8*(ln%4) +: 8] = d[8*k +: 8];
      be[bi][ln%4] = 1'b1;
    end
    b.addr = w0; b.wdata = wd[0]; b.be = be[0];
    beat_q.push_back(b);
    nb = 1;
    if (be[1] != 4'h0) begin
      b.addr = w0 + 32'd4; b.wdata = wd[1]; b.be = be[1];
      beat_q.push_back(b);
      nb = 2;
    end
    ent_q.push_back(nb);
  endfunction

  always @(posedge clk or posedge rst) begin
    int n_before;
    if (rst) begin
      beat_q.delete();
      ent_q.delete();
      err_exp = 1'b0;
    end else begin
      n_before = ent_q.size();
      err_exp  = 1'b0;
      if (beat_q.size() > 0 && bus.mem_ack) begin
        void'(beat_q.pop_front());
        ent_q[0] = ent_q[0] - 1;
        if (ent_q[0] == 0) void'(ent_q.pop_front());
      end
      if (bus.st_valid && n_before < DEPTH) begin
        acc_cnt++;
        if (bus.st_ctl > 3'd2) err_exp = 1'b1;
        else push_store(bus.st_addr, bus.st_data, bus.st_ctl);
      end
    end
  end

  function automatic logic model_conflict(input logic [31:0] la);
    for (int i = 0; i < beat_q.size(); i++)
      if (beat_q[i].addr[31:2] == la[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("st_ready", bus.st_ready, ent_q.size() < DEPTH);
      check("busy", bus.busy, ent_q.size() != 0);
      check("mem_req", bus.mem_req, beat_q.size() != 0);
      check("st_err", bus.st_err, err_exp);
      check("ld_conflict", bus.ld_conflict, model_conflict(bus.ld_addr));
      if (beat_q.size() != 0) begin
        check("mem_addr", bus.mem_addr, beat_q[0].addr);
        check("mem_wdata", bus.mem_wdata, beat_q[0].wdata);
        check("mem_be", bus.mem_be, beat_q[0].be);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_ctl   = c;
  endtask

  // Presents a store and returns at the negedge just after it is accepted.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    int c0;
    c0 = acc_cnt;
    set_st(1'b1, a, d, c);
    for (int n = 0; n < 40 && acc_cnt == c0; n++) @(negedge clk);
    checks++;
    if (acc_cnt == c0) begin
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept of addr %h", a);
    end
  endtask

  task automatic drain();
    bus.mem_ack = 1'b1;
    for (int n = 0; n < 40 && bus.busy; n++) @(negedge clk);
    check("drain_busy", bus.busy, 1'b0);
    #1;
  endtask

  task automatic chk_beat(input string nm, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    check({nm, "_req"}, bus.mem_req, 1'b1);
    check({nm, "_addr"}, bus.mem_addr, a);
    check({nm, "_be"}, bus.mem_be, be);
    check({nm, "_wdata"}, bus.mem_wdata, wd);
  endtask

  logic [31:0] pool [4];

  initial begin
    pool[0] = 32'h0000_0100; pool[1] = 32'h0000_0104;
    pool[2] = 32'h0000_0200; pool[3] = 32'hFFFF_FFFC;
    set_st(1'b0, 32'h0, 32'h0, 3'd0);
    bus.ld_addr = 32'h0;
    bus.mem_ack = 1'b0;

    #3;
    check("rst_st_ready", bus.st_ready, 1'b1);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_st_err", bus.st_err, 1'b0);
    check("rst_ld_conflict", bus.ld_conflict, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_be", bus.mem_be, 4'h0);
    @(negedge clk); #1 rst = 1'b0;

    // aligned SW, ack tied high
    bus.mem_ack = 1'b1;
    issue(32'h100, 32'hE7C3A50F, 3'd0);
    chk_beat("sw_al", 32'h100, 4'b1111, 32'hE7C3A50F);
    #1 set_st(1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk); #1;

    // SB then SH back to back
    issue(32'h103, 32'h000000A5, 3'd2);
    chk_beat("sb", 32'h100, 4'b1000, 32'hA5000000);
    #1 issue(32'h102, 32'h0000C3E7, 3'd1);
    chk_beat("sh", 32'h100, 4'b1100, 32'hC3E70000);

    // misaligned SW split
    #1 issue(32'h101, 32'h11223344, 3'd0);
    chk_beat("split_b0", 32'h100, 4'b1110, 32'h22334400);
    #1 set_st(1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    chk_beat("split_b1", 32'h104, 4'b0001, 32'h00000011);
    #1 drain();

    // back-pressure: ack held low, buffer fills
    bus.mem_ack = 1'b0;
    issue(32'h100, 32'hAAAA0001, 3'd0);
    #1 issue(32'h200, 32'hAAAA0002, 3'd0);
    check("full_st_ready", bus.st_ready, 1'b0);
    #1 set_st(1'b1, 32'h300, 32'hAAAA0003, 3'd0);
    bus.ld_addr = 32'h100;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk_beat("stall", 32'h100, 4'b1111, 32'hAAAA0001);
      check("stall_conflict", bus.ld_conflict, 1'b1);
    end
    #1 bus.ld_addr = 32'h202;
    @(negedge clk);
    check("conflict_2nd", bus.ld_conflict, 1'b1);
    #1 bus.ld_addr = 32'h400;
    @(negedge clk);
    check("no_conflict", bus.ld_conflict, 1'b0);
    #1 bus.mem_ack = 1'b1;
    issue(32'h300, 32'hAAAA0003, 3'd0);
    #1 set_st(1'b0, 32'h0, 32'h0, 3'd0);
    drain();

    // illegal ctl, then wrap-around split
    issue(32'h100, 32'h12345678, 3'd3);
    check("illegal_err", bus.st_err, 1'b1);
    check("illegal_req", bus.mem_req, 1'b0);
    #1 set_st(1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    check("illegal_err_pulse", bus.st_err, 1'b0);
    #1 issue(32'hFFFFFFFE, 32'hAABBCCDD, 3'd0);
    chk_beat("wrap_b0", 32'hFFFFFFFC, 4'b1100, 32'hCCDD0000);
    #1 set_st(1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    chk_beat("wrap_b1", 32'h00000000, 4'b0011, 32'h0000AABB);
    #1 drain();

    // reset during beat1
    issue(32'h101, 32'h55667788, 3'd0);
    #1 set_st(1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    check("pre_rst_be", bus.mem_be, 4'b0001);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_req", bus.mem_req, 1'b0);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_ready", bus.st_ready, 1'b1);
    @(negedge clk); #1 rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("post_rst_req", bus.mem_req, 1'b0);
    end
    #1;

    // random traffic
    for (int it = 0; it < 600; it++) begin
      int r;
      logic [2:0] c;
      r = int'($urandom_range(0, 9));
      c = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      set_st(1'($urandom_range(0, 1)),
             pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3)),
             $urandom, c);
      bus.ld_addr = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 7));
      bus.mem_ack = ($urandom_range(0, 3) != 0);
      @(negedge clk); #1;
    end
    set_st(1'b0, 32'h0, 32'h0, 3'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
